dequantize_stage: RTL and testbench

DEQUANTIZE_STAGE -- requirements
Module: dequantize_stage

---
 rtl/dequantize_stage.sv | 153 +++++++++++++++
 tb/tb_dequantize_stage.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dequantize_stage.sv
// Dequantizer for one N*N coefficient block.
// A 3-stage pipeline: S1 registers the level with its scale/shift, S2 multiplies
// and applies the QP/6 up-shift, and S3 rounds, shifts down by BDSHIFT and clips.
// QP is captured on the first beat of each block and held for the rest of it.
// Block framing is tracked by a beat counter. Short and long blocks raise a
// one-cycle len_err pulse, and the counter resynchronizes after either case.
module dequantize_stage #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int B     = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [5:0]              qp_i,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    len_err
);

  localparam int STAGES  = 3;
  localparam int BDSHIFT = B + $clog2(N) - 5;
  localparam int CW      = $clog2(N*N);
  // The product needs WIDTH bits plus 8 bits of scale (scale is at most 72).
  localparam int PW      = WIDTH + 8;
  // Adding 9 bits of headroom lets the product take a shift_up of up to 8.
  localparam int QW      = PW + 9;

  localparam logic [CW-1:0]        LAST_BEAT = CW'(N*N-1);
  localparam logic [5:0]           QP_MAX    = 6'd51;
  localparam logic signed [QW-1:0] RND       = QW'(2**(BDSHIFT-1));
  localparam logic signed [QW-1:0] SMAX      = QW'((2**(WIDTH-1)) - 1);
  localparam logic signed [QW-1:0] SMIN      = ~SMAX;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [7:0]       scale;
    logic [3:0]       shift;
    logic             last;
  } s1_t;

  function automatic logic [7:0] scale_of(input logic [5:0] qp);
    logic [5:0] rem;
    rem = qp % 6'd6;
    case (rem)
      6'd0:    scale_of = 8'd40;
      6'd1:    scale_of = 8'd45;
      6'd2:    scale_of = 8'd51;
      6'd3:    scale_of = 8'd57;
      6'd4:    scale_of = 8'd64;
      default: scale_of = 8'd72;
    endcase
  endfunction

  function automatic logic [3:0] shift_of(input logic [5:0] qp);
    shift_of = 4'(qp / 6'd6);
  endfunction

  logic [CW-1:0]        cnt;
  logic [5:0]           qp_lat;
  logic [STAGES:1]      vld_pipe;
  s1_t                  s1, s1_d;
  logic signed [QW-1:0] s2_q;
  logic                 s2_last;

  logic                 en, acc, at_end, short_blk, long_blk;
  logic [5:0]           qp_clamp, qp_use;
  logic signed [PW-1:0] data_x, scale_x, p;
  logic signed [QW-1:0] q, sum, r;
  logic [WIDTH-1:0]     sat;

  // The whole pipeline moves as one unit. It stalls only when the output is held.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign acc      = in_valid && en;
  assign busy     = (cnt != '0) || (|vld_pipe);

  assign at_end    = (cnt == LAST_BEAT);
  assign short_blk = in_last && !at_end;
  assign long_blk  = at_end && !in_last;

  // The first beat of a block uses the live QP. Later beats use the latched copy.
  assign qp_clamp = (qp_i > QP_MAX) ? QP_MAX : qp_i;
  assign qp_use   = (cnt == '0) ? qp_clamp : qp_lat;

  // A long block is cut at the last beat, so last is forced there.
  assign s1_d = '{data:  in_data,
                  scale: scale_of(qp_use),
                  shift: shift_of(qp_use),
                  last:  in_last || at_end};

  // S2 math: a signed level times a positive scale, then the QP/6 up-shift.
  assign data_x  = {{(PW-WIDTH){s1.data[WIDTH-1]}}, s1.data};
  assign scale_x = {{(PW-8){1'b0}}, s1.scale};
  assign p       = data_x * scale_x;
  assign q       = {{(QW-PW){p[PW-1]}}, p} <<< s1.shift;

  // S3 math: round half up, arithmetic shift down, then clip to WIDTH.
  assign sum = s2_q + RND;
  assign r   = sum >>> BDSHIFT;

  // Saturate the rounded value into the signed output range.
  always_comb begin
    if (r > SMAX)      sat = SMAX[WIDTH-1:0];
    else if (r < SMIN) sat = SMIN[WIDTH-1:0];
    else               sat = r[WIDTH-1:0];
  end

  // Beat counter and per-block QP latch.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt    <= '0;
      qp_lat <= '0;
    end else if (acc) begin
      if (cnt == '0) qp_lat <= qp_clamp;
      cnt <= (in_last || at_end) ? '0 : cnt + 1'b1;
    end
  end

  // Framing error pulse. It is registered, so it shows in the cycle after the offending accept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) len_err <= 1'b0;
    else          len_err <= acc && (short_blk || long_blk);
  end

  // Pipeline registers. Bubbles ride along in vld_pipe and are never squeezed out.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      vld_pipe <= '0;
      s1       <= '0;
      s2_q     <= '0;
      s2_last  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[STAGES-1:1], acc};
      s1       <= s1_d;
      s2_q     <= q;
      s2_last  <= s1.last;
      out_data <= sat;
      out_last <= vld_pipe[STAGES-1] && s2_last;
    end
  end

  assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_dequantize_stage.sv
// Bench for dequantize_stage. It uses directed scenarios plus a randomized
// stream. Each accepted beat is scored against an arithmetic reference of the
// dequantization rule, and block framing is tracked per block.
module tb_dequantize_stage;

  logic               HCLK = 1'b0;
  logic               HRESETn;
  logic [5:0]         qp_i;
  logic               in_valid, in_ready, in_last;
  logic signed [15:0] in_data;
  logic               out_valid, out_ready, out_last, busy, len_err;
  logic signed [15:0] out_data;

  always #5 HCLK = ~HCLK;

  dequantize_stage #(.WIDTH(16), .N(8), .B(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .qp_i(qp_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .len_err(len_err)
  );

  typedef struct {
    logic signed [15:0] d;
    logic               l;
  } exp_t;

  exp_t               sb[$];
  int                 n_assert = 0;
  int                 n_fail   = 0;
  int                 bi       = 0;
  int                 qpb      = 0;
  logic               err_nxt  = 1'b0;
  logic               hold_v   = 1'b0;
  logic               hold_l   = 1'b0;
  logic signed [15:0] hold_d   = '0;
  logic               acc      = 1'b0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Reference rule: level*scale*2^(qp/6), then (x+32)/64 with floor, then clip to 16 bits.
  function automatic longint dq(input int qp, input longint x);
    longint sc, v, r;
    case (qp % 6)
      0: sc = 40;
      1: sc = 45;
      2: sc = 51;
      3: sc = 57;
      4: sc = 64;
      default: sc = 72;
    endcase
    v = x * sc * (longint'(1) << (qp / 6)) + 32;
    r = (v >= 0) ? v / 64 : -((-v + 63) / 64);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // Called at every falling edge. It runs checks, scores deliveries and records accepts.
  task automatic mon();
    exp_t e;
    logic last_eff;
    acc = 1'b0;
    if (!HRESETn) begin
      sb.delete();
      bi = 0; qpb = 0; err_nxt = 1'b0; hold_v = 1'b0;
      return;
    end
    chk("len_err", len_err, err_nxt);
    chk("in_ready_eq_en", in_ready, (!out_valid || out_ready));
    if (hold_v) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, hold_d);
      chk("hold_last", out_last, hold_l);
    end
    if (out_valid && out_ready) begin
      chk("out_expected", (sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", out_data, e.d);
        chk("out_last", out_last, e.l);
      end
    end
    hold_v  = out_valid && !out_ready;
    hold_d  = out_data;
    hold_l  = out_last;
    err_nxt = 1'b0;
    if (in_valid && in_ready) begin
      acc = 1'b1;
      if (bi == 0) qpb = (qp_i > 51) ? 51 : int'(qp_i);
      last_eff = in_last || (bi == 63);
      err_nxt  = (in_last && bi != 63) || (bi == 63 && !in_last);
      e.d = 16'(dq(qpb, in_data));
      e.l = last_eff;
      sb.push_back(e);
      bi = last_eff ? 0 : bi + 1;
    end
  endtask

  task automatic half();
    @(negedge HCLK);
    mon();
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Present one beat and hold it until it is accepted, within a bounded number of cycles.
  task automatic beat(input logic signed [15:0] d, input logic l, input logic [5:0] q);
    int   n;
    logic ok;
    n = 0; ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l; qp_i = q;
    do begin
      half(); ok = acc; step(); n++;
    end while (!ok && n < 200);
    if (!ok) chk("accept_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input logic signed [63:0] want);
    for (int i = 0; i < 12; i++) begin
      half();
      if (out_valid && out_ready) begin
        chk(tag, out_data, want);
        step();
        return;
      end
      step();
    end
    chk({tag, "_timeout"}, out_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 300) begin
      half(); step(); n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic signed [15:0] rand_data();
    int t;
    case ($urandom_range(7))
      0: t = 32767;
      1: t = -32768;
      2, 3: t = int'($signed(16'($urandom)));
      default: t = int'($urandom_range(200)) - 100;
    endcase
    return 16'(t);
  endfunction

  initial begin
    int   sent, gi, c;
    logic took;
    logic signed [15:0] d;

    HRESETn = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; qp_i = '0; out_ready = 1'b1;

    // Reset values
    half();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    step(); half(); step();
    HRESETn = 1'b1;

    // QP 4, level 10 gives 10, with out_valid exactly three cycles after the accept
    beat(16'sd10, 1'b1, 6'd4);
    half(); chk("lat_c1_invalid", out_valid, 0); step();
    half(); chk("lat_c2_invalid", out_valid, 0); step();
    half(); chk("lat_c3_valid", out_valid, 1); chk("qp4_data", out_data, 10); step();

    // QP 34, level -3 gives -96 through the arithmetic shift
    beat(-16'sd3, 1'b1, 6'd34);
    wait_out("qp34_neg", -96);

    // Saturation at QP 51, then a QP above 51 that clamps to 51
    beat(16'sd32767, 1'b0, 6'd51);
    beat(-16'sd32768, 1'b1, 6'd51);
    wait_out("sat_pos", 32767);
    wait_out("sat_neg", -32768);
    beat(16'sd100, 1'b1, 6'd63);
    wait_out("qp_clamp", 22800);

    // A full 64-beat block with a 5-cycle output stall in the middle
    for (int i = 0; i < 64; i++) begin
      d = rand_data();
      if (i == 30) begin
        in_valid = 1'b1; in_data = d; in_last = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          half();
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          step();
        end
        out_ready = 1'b1;
      end
      if (i == 40) chk("busy_mid", busy, 1);
      beat(d, (i == 63), (i == 0) ? 6'(11 + $urandom_range(20)) : 6'($urandom_range(63)));
    end
    drain();
    half(); chk("busy_idle", busy, 0); chk("idle_out_valid", out_valid, 0); step();

    // A short block ending at beat 9, then QP re-latched on the next beat
    for (int i = 0; i < 10; i++)
      beat(rand_data(), (i == 9), (i == 0) ? 6'd10 : 6'd47);
    half(); chk("short_len_err", len_err, 1); step();
    drain();
    beat(16'sd200, 1'b1, 6'd30);
    wait_out("qp_relatch", 4000);

    // A long block with no in_last, which is cut at beat 63
    for (int i = 0; i < 64; i++) beat(16'(i - 32), 1'b0, 6'd7);
    half(); chk("long_len_err", len_err, 1); step();
    drain();

    // Randomized traffic with valid gaps, output backpressure and mixed framing
    sent = 0; gi = 0; c = 0;
    while ((sent < 400 || in_valid) && c < 5000) begin
      half(); took = acc; step(); c++;
      if (took || !in_valid) begin
        if (sent < 400 && $urandom_range(3) != 0) begin
          in_valid = 1'b1;
          in_data  = rand_data();
          qp_i     = 6'($urandom_range(63));
          in_last  = (gi == 63) ? ($urandom_range(3) != 0) : ($urandom_range(39) == 0);
          gi       = (in_last || gi == 63) ? 0 : gi + 1;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(3) != 0);
    end
    chk("rand_all_sent", sent, 400);
    chk("rand_input_idle", in_valid, 0);
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    // Return the beat counter to 0 if the random stream ended mid-block
    if (bi != 0) begin
      beat(16'sd0, 1'b1, 6'd0);
      drain();
    end

    // Reset with two beats in flight
    beat(16'sd5, 1'b0, 6'd40);
    beat(16'sd6, 1'b0, 6'd40);
    HRESETn = 1'b0;
    #1;
    chk("rst_flight_out_valid", out_valid, 0);
    chk("rst_flight_busy", busy, 0);
    chk("rst_flight_in_ready", in_ready, 1);
    half(); step();
    HRESETn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      half(); chk("post_rst_no_stale", out_valid, 0); step();
    end
    beat(16'sd10, 1'b1, 6'd4);
    wait_out("post_rst_qp", 10);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
